// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 register-file writeback path.
//   XLEN   : integer register width
//   AW     : register address width (32 registers)
//   ReqAlu : requester index of the ALU writeback port
//   ReqLd  : requester index of the load-unit writeback port
package msrv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned ReqAlu = 0;
  localparam int unsigned ReqLd  = 1;

endpackage

// File: rtl/msrv32_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clk_i  : clock
//   rst_ni : synchronous active-low reset; forces grants low and re-arms the pointer
//   req_i  : request vector, indexed by ReqAlu / ReqLd
//   gnt_o  : one-hot (or zero) grant, combinational from req_i and the pointer
module msrv32_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  import msrv32_pkg::*;

  // 1 when the load unit held the most recent grant.
  logic last_ld_q;

  always_comb begin
    gnt_o = 2'b00;
    if (rst_ni) begin
      if (req_i[ReqAlu] && req_i[ReqLd]) begin
        gnt_o[ReqAlu] = last_ld_q;
        gnt_o[ReqLd]  = ~last_ld_q;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  // Pointer moves only on an actual grant; reset marks the ALU as last winner so the
  // load unit takes the first contention.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_ld_q <= 1'b0;
    end else if (|gnt_o) begin
      last_ld_q <= gnt_o[ReqLd];
    end
  end

endmodule

// File: rtl/msrv32_rf_wr_arbiter.sv
// Integer register-file write-port arbiter between the ALU and the load unit.
//   clk_in, rst_in               : clock, synchronous active-low reset
//   alu_valid/addr/data_in       : ALU writeback request; alu_ready_out = accepted this cycle
//   ld_valid/addr/data_in        : load writeback request; ld_ready_out = accepted this cycle
//   wr_en_out, rd_addr_out,
//   rd_out                       : registered write port into the integer file
//   rs_1_addr_in, rs_2_addr_in   : decode-stage source registers
//   stall_out                    : a source register has an uncommitted write in flight
module msrv32_rf_wr_arbiter #(
  parameter int unsigned XLEN = msrv32_pkg::XLEN,
  parameter int unsigned AW   = msrv32_pkg::AW
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            alu_valid_in,
  input  logic [AW-1:0]   alu_addr_in,
  input  logic [XLEN-1:0] alu_data_in,
  output logic            alu_ready_out,
  input  logic            ld_valid_in,
  input  logic [AW-1:0]   ld_addr_in,
  input  logic [XLEN-1:0] ld_data_in,
  output logic            ld_ready_out,
  output logic            wr_en_out,
  output logic [AW-1:0]   rd_addr_out,
  output logic [XLEN-1:0] rd_out,
  input  logic [AW-1:0]   rs_1_addr_in,
  input  logic [AW-1:0]   rs_2_addr_in,
  output logic            stall_out
);

  import msrv32_pkg::*;

  logic [1:0]      req;
  logic [1:0]      gnt;
  logic            accept;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic            wr_en_q;
  logic [AW-1:0]   rd_addr_q;
  logic [XLEN-1:0] rd_data_q;
  logic            alu_pend;
  logic            ld_pend;
  logic            hit_1;
  logic            hit_2;

  always_comb begin
    req         = 2'b00;
    req[ReqAlu] = alu_valid_in;
    req[ReqLd]  = ld_valid_in;
  end

  msrv32_rr_arb2 u_arb (
    .clk_i  (clk_in),
    .rst_ni (rst_in),
    .req_i  (req),
    .gnt_o  (gnt)
  );

  assign alu_ready_out = gnt[ReqAlu];
  assign ld_ready_out  = gnt[ReqLd];
  assign accept        = |gnt;

  always_comb begin
    sel_addr = alu_addr_in;
    sel_data = alu_data_in;
    if (gnt[ReqLd]) begin
      sel_addr = ld_addr_in;
      sel_data = ld_data_in;
    end
  end

  // Writes to x0 are accepted but dropped; address/data keep their last committed values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (accept && (sel_addr != '0)) begin
      wr_en_q   <= 1'b1;
      rd_addr_q <= sel_addr;
      rd_data_q <= sel_data;
    end else begin
      wr_en_q   <= 1'b0;
    end
  end

  // The file samples wr_en_out on the same edge that applies reset, so a pending write
  // is masked by rst_in to keep it from landing while reset is being taken.
  assign wr_en_out   = wr_en_q & rst_in;
  assign rd_addr_out = rd_addr_q;
  assign rd_out      = rd_data_q;

  // Hazard: a waiting request (valid, not granted) or the registered write in flight.
  assign alu_pend = alu_valid_in & ~gnt[ReqAlu];
  assign ld_pend  = ld_valid_in & ~gnt[ReqLd];

  assign hit_1 = (rs_1_addr_in != '0) &&
                 ((alu_pend && (alu_addr_in == rs_1_addr_in)) ||
                  (ld_pend && (ld_addr_in == rs_1_addr_in)) ||
                  (wr_en_out && (rd_addr_out == rs_1_addr_in)));
  assign hit_2 = (rs_2_addr_in != '0) &&
                 ((alu_pend && (alu_addr_in == rs_2_addr_in)) ||
                  (ld_pend && (ld_addr_in == rs_2_addr_in)) ||
                  (wr_en_out && (rd_addr_out == rs_2_addr_in)));

  assign stall_out = hit_1 | hit_2;

endmodule

// File: tb/tb_msrv32_rf_wr_arbiter.sv
module tb_msrv32_rf_wr_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        alu_valid_in;
  logic [4:0]  alu_addr_in;
  logic [31:0] alu_data_in;
  logic        alu_ready_out;
  logic        ld_valid_in;
  logic [4:0]  ld_addr_in;
  logic [31:0] ld_data_in;
  logic        ld_ready_out;
  logic        wr_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] rd_out;
  logic [4:0]  rs_1_addr_in;
  logic [4:0]  rs_2_addr_in;
  logic        stall_out;

  int n_checks = 0;
  int n_fail   = 0;
  int rf9_writes = 0;

  msrv32_rf_wr_arbiter #(
    .XLEN (32),
    .AW   (5)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .alu_valid_in  (alu_valid_in),
    .alu_addr_in   (alu_addr_in),
    .alu_data_in   (alu_data_in),
    .alu_ready_out (alu_ready_out),
    .ld_valid_in   (ld_valid_in),
    .ld_addr_in    (ld_addr_in),
    .ld_data_in    (ld_data_in),
    .ld_ready_out  (ld_ready_out),
    .wr_en_out     (wr_en_out),
    .rd_addr_out   (rd_addr_out),
    .rd_out        (rd_out),
    .rs_1_addr_in  (rs_1_addr_in),
    .rs_2_addr_in  (rs_2_addr_in),
    .stall_out     (stall_out)
  );

  always #5 clk_in = ~clk_in;

  // Integer file stand-in: count commits to x9.
  always @(posedge clk_in) begin
    if (wr_en_out && (rd_addr_out == 5'd9)) rf9_writes <= rf9_writes + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid_in = av;
    alu_addr_in  = aa;
    alu_data_in  = ad;
    ld_valid_in  = lv;
    ld_addr_in   = la;
    ld_data_in   = ld;
  endtask

  initial begin
    rst_in       = 1'b0;
    rs_1_addr_in = 5'd0;
    rs_2_addr_in = 5'd0;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);

    // Reset held two edges with both requesters valid.
    #1;
    check_eq("rst_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    check_eq("rst_ld_ready", {31'd0, ld_ready_out}, 32'd0);
    tick();
    tick();
    check_eq("rst_wr_en", {31'd0, wr_en_out}, 32'd0);
    check_eq("rst_rd_out", rd_out, 32'd0);
    check_eq("rst_rd_addr", {27'd0, rd_addr_out}, 32'd0);
    check_eq("rst_alu_ready2", {31'd0, alu_ready_out}, 32'd0);

    // First contention after reset goes to the load unit.
    rst_in = 1'b1;
    #1;
    check_eq("first_ld_ready", {31'd0, ld_ready_out}, 32'd1);
    check_eq("first_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    tick();
    check_eq("first_rd_addr", {27'd0, rd_addr_out}, 32'd2);

    // ALU alone.
    drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0);
    #1;
    check_eq("alu_only_ready", {31'd0, alu_ready_out}, 32'd1);
    check_eq("alu_only_ld_ready", {31'd0, ld_ready_out}, 32'd0);
    tick();
    check_eq("alu_only_wr_en", {31'd0, wr_en_out}, 32'd1);
    check_eq("alu_only_rd_addr", {27'd0, rd_addr_out}, 32'd5);
    check_eq("alu_only_rd_out", rd_out, 32'h12345678);

    // Both held four cycles: ALU was last, so LD, ALU, LD, ALU.
    drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB);
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr_ld_ready_%0d", i), {31'd0, ld_ready_out},
               (i % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("rr_alu_ready_%0d", i), {31'd0, alu_ready_out},
               (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check_eq($sformatf("rr_rd_addr_%0d", i), {27'd0, rd_addr_out},
               (i % 2 == 0) ? 32'd4 : 32'd3);
      check_eq($sformatf("rr_rd_out_%0d", i), rd_out, (i % 2 == 0) ? 32'hB : 32'hA);
    end

    // Write to x0: accepted, no file write, outputs hold.
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0);
    #1;
    check_eq("x0_alu_ready", {31'd0, alu_ready_out}, 32'd1);
    tick();
    check_eq("x0_wr_en", {31'd0, wr_en_out}, 32'd0);
    check_eq("x0_rd_addr_hold", {27'd0, rd_addr_out}, 32'd3);
    check_eq("x0_rd_out_hold", rd_out, 32'hA);

    // Idle cycle.
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("idle_wr_en", {31'd0, wr_en_out}, 32'd0);

    // LD alone to make LD the last winner, then ALU 7 beats LD 10.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h5);
    tick();
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd10, 32'h100);
    rs_1_addr_in = 5'd10;
    #1;
    check_eq("haz_alu_ready", {31'd0, alu_ready_out}, 32'd1);
    check_eq("haz_ld_ready", {31'd0, ld_ready_out}, 32'd0);
    check_eq("haz_stall_pending_ld", {31'd0, stall_out}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    rs_1_addr_in = 5'd0;
    rs_2_addr_in = 5'd7;
    #1;
    check_eq("haz_stall_inflight", {31'd0, stall_out}, 32'd1);
    rs_2_addr_in = 5'd0;
    #1;
    check_eq("haz_stall_clear", {31'd0, stall_out}, 32'd0);

    // Both to x0: one waits with address 0, source x0 must not stall.
    drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2);
    #1;
    check_eq("x0_ld_ready", {31'd0, ld_ready_out}, 32'd1);
    check_eq("x0_no_stall", {31'd0, stall_out}, 32'd0);
    tick();

    // Accept ALU x9, then reset before it commits.
    drive(1'b1, 5'd9, 32'hABCDEF01, 1'b0, 5'd0, 32'h0);
    tick();
    check_eq("x9_wr_en", {31'd0, wr_en_out}, 32'd1);
    check_eq("x9_rd_addr", {27'd0, rd_addr_out}, 32'd9);
    rst_in = 1'b0;
    drive(1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6);
    #1;
    check_eq("mid_rst_alu_ready", {31'd0, alu_ready_out}, 32'd0);
    check_eq("mid_rst_ld_ready", {31'd0, ld_ready_out}, 32'd0);
    tick();
    check_eq("mid_rst_wr_en", {31'd0, wr_en_out}, 32'd0);
    check_eq("mid_rst_rd_out", rd_out, 32'd0);
    tick();
    check_eq("x9_not_written", rf9_writes, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_rf_wr_arbiter.md
MSRV32_RF_WR_ARBITER -- requirements
Module: msrv32_rf_wr_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the integer file write port.
REQ-002 SHALL have parameter AW, default 5, register address width (32 registers).
REQ-003 SHALL have port clk_in  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports alu_valid_in, alu_addr_in[AW-1:0], alu_data_in[XLEN-1:0]  input  ALU writeback request, target register and value.
REQ-006 SHALL have port alu_ready_out  output  1  ALU request accepted this cycle.
REQ-007 SHALL have ports ld_valid_in, ld_addr_in[AW-1:0], ld_data_in[XLEN-1:0]  input  load-unit writeback request.
REQ-008 SHALL have port ld_ready_out  output  1  load request accepted this cycle.
REQ-009 SHALL have ports wr_en_out 1, rd_addr_out AW, rd_out XLEN  output  registered write port driving the integer file.
REQ-010 SHALL have ports rs_1_addr_in, rs_2_addr_in  input  AW  decode-stage source addresses for hazard check.
REQ-011 SHALL have port stall_out  output  1  a source register has a write not yet committed to the integer file.

Function
REQ-012 SHALL accept at most one request per cycle; accept means valid and ready both high at a rising edge.
REQ-013 SHALL grant by round-robin: when both valid, grant the requester not granted most recently; a single valid requester is granted immediately.
REQ-014 SHALL update the last-grant pointer only on an accepted request; idle cycles leave it unchanged.
REQ-015 SHALL drive ready combinationally from valid and pointer; a ready SHALL never be high for a requester whose valid is low.
REQ-016 SHALL register the accepted request: request accepted at edge N yields wr_en_out=1, rd_addr_out, rd_out valid during cycle N..N+1 (one-cycle latency).
REQ-017 SHALL hold wr_en_out low in any cycle following an edge with no acceptance.
REQ-018 SHALL accept a request addressed to register 0 (ready high) but SHALL keep wr_en_out low for it; rd_addr_out and rd_out SHALL hold their previous values.
REQ-019 SHALL keep a requester's address and data stable while it waits; the arbiter SHALL not store a losing request internally.
REQ-020 SHALL assert stall_out when a nonzero rs_1_addr_in or rs_2_addr_in equals (a) the address of any valid request not accepted this cycle, or (b) rd_addr_out while wr_en_out is high.
REQ-021 SHALL never assert stall_out for source address 0.
REQ-022 SHALL, when both requesters target the same register, commit them in grant order so the later grant's data persists.

Reset
REQ-023 SHALL, while rst_in is low at a rising edge, clear wr_en_out to 0, rd_addr_out to 0, rd_out to 0, and set the last-grant pointer so the load unit wins the first contention.
REQ-024 SHALL drive alu_ready_out, ld_ready_out low while rst_in is low; requests presented during reset are not accepted.
REQ-025 SHALL, on reset asserted mid-operation, discard the registered write so no write reaches the integer file on the cycle after reset.

Structure
REQ-026 SHALL take XLEN, AW and the requester index constants (ALU=0, LD=1) from shared package msrv32_pkg.
REQ-027 SHALL instantiate one sub-module, msrv32_rr_arb2, holding the pointer and producing the one-hot grant; the output register and hazard logic stay in the top level.

Verification
REQ-028 SHALL cover: reset low 2 cycles with both valid -> both ready 0, wr_en_out 0, rd_out 0.
REQ-029 SHALL cover: ALU alone, addr 5, data 32'h12345678 -> alu_ready_out 1 same cycle; next cycle wr_en_out 1, rd_addr_out 5, rd_out 32'h12345678.
REQ-030 SHALL cover: both valid held 4 cycles, ALU addr 3/data 32'hA, LD addr 4/data 32'hB -> grants LD, ALU, LD, ALU; rd_addr_out 4,3,4,3 one cycle later.
REQ-031 SHALL cover: ALU addr 0, data 32'hFFFFFFFF -> alu_ready_out 1, wr_en_out stays 0.
REQ-032 SHALL cover: LD valid addr 10 losing to ALU addr 7, rs_1_addr_in 10 -> stall_out 1; next cycle rs_2_addr_in 7 -> stall_out 1 (registered write pending); rs_1_addr_in 0 -> stall_out 0.
REQ-033 SHALL cover: accept ALU addr 9 data 32'hABCDEF01, then rst_in low next edge -> wr_en_out 0 after that edge, integer file register 9 unchanged.
